// File: rtl/univ_shift_register.sv
// Universal shift register: parametrised width, shift/rotate/arithmetic
// shift, parallel load and clear, plus an autonomous burst engine that
// applies a latched shift mode a given number of times with busy/done.
module univ_shift_register #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             din_l,
    input  logic             din_r,
    input  logic [WIDTH-1:0] pdata,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] Q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] remain, remain_nxt;
    logic [2:0]       lmode, lmode_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             done_nxt;
    logic             shift_type;

    // One application of an operation code to the current register value.
    function automatic logic [WIDTH-1:0] apply_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] cur,
        input logic             dl,
        input logic             dr,
        input logic [WIDTH-1:0] ld
    );
        logic [WIDTH-1:0] res;
        case (op)
            3'b001:  res = {dr, cur[WIDTH-1:1]};
            3'b010:  res = {cur[WIDTH-2:0], dl};
            3'b011:  res = {cur[0], cur[WIDTH-1:1]};
            3'b100:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
            3'b101:  res = ld;
            3'b110:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
            3'b111:  res = '0;
            default: res = cur;
        endcase
        return res;
    endfunction

    // Modes that may be repeated by the burst engine.
    always_comb begin
        shift_type = 1'b0;
        case (mode)
            3'b001, 3'b010, 3'b011, 3'b100, 3'b110: shift_type = 1'b1;
            default:                                shift_type = 1'b0;
        endcase
    end

    // State register: FSM state, burst bookkeeping, data and done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            remain <= '0;
            lmode  <= '0;
            Q      <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            remain <= remain_nxt;
            lmode  <= lmode_nxt;
            Q      <= q_nxt;
            done   <= done_nxt;
        end
    end

    // Next-state logic: burst acceptance, manual ops and burst stepping.
    always_comb begin
        state_nxt  = state;
        remain_nxt = remain;
        lmode_nxt  = lmode;
        q_nxt      = Q;
        done_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (start && shift_type && (count != '0)) begin
                    state_nxt  = BUSY;
                    remain_nxt = count;
                    lmode_nxt  = mode;
                end else if (start && shift_type) begin
                    done_nxt = 1'b1;
                end else if (en) begin
                    q_nxt = apply_op(mode, Q, din_l, din_r, pdata);
                end
            end
            BUSY: begin
                q_nxt      = apply_op(lmode, Q, din_l, din_r, pdata);
                remain_nxt = remain - 1'b1;
                if (remain == CNT_W'(1)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from registered state.
    always_comb begin
        busy   = (state == BUSY);
        sout_l = Q[WIDTH-1];
        sout_r = Q[0];
    end

endmodule

// File: tb/tb_univ_shift_register.sv
// Self-checking bench for univ_shift_register: directed vector table,
// an asynchronous-reset sequence, and randomized traffic against a
// behavioural model.
module tb_univ_shift_register;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [2:0]    mode;
    logic          din_l, din_r;
    logic [W-1:0]  pdata;
    logic          start;
    logic [CW-1:0] count;
    logic [W-1:0]  Q;
    logic          sout_l, sout_r, busy, done;

    int vectors    = 0;
    int miscompares = 0;

    univ_shift_register #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .din_l(din_l),
        .din_r(din_r), .pdata(pdata), .start(start), .count(count),
        .Q(Q), .sout_l(sout_l), .sout_r(sout_r), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          en;
        logic [2:0]    mode;
        logic          dl;
        logic          dr;
        logic [W-1:0]  pd;
        logic          st;
        logic [CW-1:0] cnt;
        logic [W-1:0]  eq;
        logic          eb;
        logic          ed;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic e, input logic [2:0] m, input logic dl,
                       input logic dr, input logic [W-1:0] pd, input logic st,
                       input logic [CW-1:0] c, input logic [W-1:0] eq,
                       input logic eb, input logic ed);
        vec_t v;
        v.en = e; v.mode = m; v.dl = dl; v.dr = dr; v.pd = pd;
        v.st = st; v.cnt = c; v.eq = eq; v.eb = eb; v.ed = ed;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [W-1:0] eq,
                         input logic eb, input logic ed);
        vectors++;
        if (Q !== eq || busy !== eb || done !== ed ||
            sout_l !== eq[W-1] || sout_r !== eq[0]) begin
            miscompares++;
            $display("FAIL %s: got Q=%h busy=%b done=%b sl=%b sr=%b, want Q=%h busy=%b done=%b",
                     name, Q, busy, done, sout_l, sout_r, eq, eb, ed);
        end
    endtask

    task automatic drive(input logic e, input logic [2:0] m, input logic dl,
                         input logic dr, input logic [W-1:0] pd,
                         input logic st, input logic [CW-1:0] c);
        en = e; mode = m; din_l = dl; din_r = dr; pdata = pd;
        start = st; count = c;
    endtask

    // Behavioural model: integer register value and a remaining-shift count.
    int mq, rem, lm;
    bit mdone;

    function automatic int op_model(int m, int q, int dl, int dr, int pd);
        int msb = 1 << (W - 1);
        int mod = 1 << W;
        case (m)
            1: return (q / 2) + (dr ? msb : 0);
            2: return ((q * 2) + dl) % mod;
            3: return (q / 2) + ((q % 2) ? msb : 0);
            4: return ((q * 2) % mod) + (q / msb);
            5: return pd;
            6: return (q / 2) + (q & msb);
            7: return 0;
            default: return q;
        endcase
    endfunction

    function automatic bit is_shift(int m);
        return (m == 1 || m == 2 || m == 3 || m == 4 || m == 6);
    endfunction

    task automatic model_step();
        if (rem > 0) begin
            mq = op_model(lm, mq, din_l, din_r, pdata);
            rem--;
            mdone = (rem == 0);
        end else begin
            mdone = 1'b0;
            if (start && is_shift(mode) && count != 0) begin
                rem = count;
                lm  = mode;
            end else if (start && is_shift(mode)) begin
                mdone = 1'b1;
            end else if (en) begin
                mq = op_model(mode, mq, din_l, din_r, pdata);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 0, '0, 0, '0);
        #2;
        check("reset_state", 8'h00, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;

        //   en mode dl dr pdata st cnt  expQ  busy done
        add(1, 5, 0, 0, 8'hA5, 0, 0, 8'hA5, 0, 0);
        add(1, 1, 0, 1, 8'h00, 0, 0, 8'hD2, 0, 0);
        add(1, 2, 0, 0, 8'h00, 0, 0, 8'hA4, 0, 0);
        add(0, 2, 1, 1, 8'h00, 0, 0, 8'hA4, 0, 0);
        add(1, 5, 0, 0, 8'h81, 0, 0, 8'h81, 0, 0);
        add(1, 4, 0, 0, 8'h00, 0, 0, 8'h03, 0, 0);
        add(1, 5, 0, 0, 8'h81, 0, 0, 8'h81, 0, 0);
        add(1, 3, 0, 0, 8'h00, 0, 0, 8'hC0, 0, 0);
        add(1, 5, 0, 0, 8'h80, 0, 0, 8'h80, 0, 0);
        add(1, 6, 0, 0, 8'h00, 0, 0, 8'hC0, 0, 0);
        add(1, 6, 0, 0, 8'h00, 0, 0, 8'hE0, 0, 0);
        add(1, 5, 0, 0, 8'h01, 0, 0, 8'h01, 0, 0);
        add(1, 2, 0, 0, 8'h00, 1, 3, 8'h01, 1, 0);
        add(1, 7, 0, 0, 8'h00, 0, 0, 8'h02, 1, 0);
        add(1, 5, 0, 0, 8'hFF, 1, 9, 8'h04, 1, 0);
        add(0, 0, 0, 0, 8'h00, 0, 0, 8'h08, 0, 1);
        add(0, 0, 0, 0, 8'h00, 0, 0, 8'h08, 0, 0);
        add(1, 2, 1, 0, 8'h00, 1, 0, 8'h08, 0, 1);
        add(0, 0, 0, 0, 8'h00, 0, 0, 8'h08, 0, 0);
        add(1, 5, 0, 0, 8'h3C, 1, 3, 8'h3C, 0, 0);
        add(1, 1, 0, 0, 8'h00, 1, 2, 8'h3C, 1, 0);
        add(1, 1, 0, 0, 8'h00, 1, 2, 8'h1E, 1, 0);
        add(1, 1, 0, 0, 8'h00, 1, 2, 8'h0F, 0, 1);
        add(1, 1, 0, 0, 8'h00, 1, 2, 8'h0F, 1, 0);
        add(0, 0, 0, 0, 8'h00, 0, 0, 8'h07, 1, 0);
        add(0, 0, 0, 0, 8'h00, 0, 0, 8'h03, 0, 1);
        add(0, 0, 0, 0, 8'h00, 0, 0, 8'h03, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].en, tbl[i].mode, tbl[i].dl, tbl[i].dr, tbl[i].pd,
                  tbl[i].st, tbl[i].cnt);
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), tbl[i].eq, tbl[i].eb, tbl[i].ed);
        end

        // Asynchronous reset in the middle of a burst.
        drive(1, 5, 0, 0, 8'h55, 0, 0);
        @(posedge clk); #1;
        drive(0, 3, 0, 0, 8'h00, 1, 5);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 8'h00, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("async_reset", 8'h00, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check($sformatf("post_reset%0d", i), 8'h00, 1'b0, 1'b0);
        end

        // Randomized traffic against the model.
        mq = 0; rem = 0; lm = 0; mdone = 1'b0;
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  W'($urandom), ($urandom_range(0, 3) == 0),
                  CW'($urandom_range(0, 4)));
            model_step();
            @(posedge clk); #1;
            check($sformatf("rand%0d", i), W'(mq), (rem > 0), mdone);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/univ_shift_register.md
Name: univ_shift_register

Overview:
Parametrised universal shift register. It is the successor to the fixed 4-bit serial-in shift register in the Sequential library. It adds configurable width, bidirectional shift, rotate, arithmetic shift, parallel load and clear. A burst engine performs N shifts autonomously, with a busy/done handshake. Intended for serializers, LFSR/CRC front-ends and test-pattern generators.

Parameters:
WIDTH, 8, register width in bits (>=2)
CNT_W, 4, width of burst count (max burst = 2^CNT_W-1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-low
en  input  1  enables manual (single-cycle) operations in IDLE
mode  input  3  operation select (see Behaviour)
din_l  input  1  serial in, enters bit 0 on shift-left
din_r  input  1  serial in, enters bit WIDTH-1 on shift-right
pdata  input  WIDTH  parallel load data
start  input  1  burst request (level-sampled)
count  input  CNT_W  number of shifts for burst
Q  output  WIDTH  register contents
sout_l  output  1  Q[WIDTH-1], combinational from Q
sout_r  output  1  Q[0], combinational from Q
busy  output  1  burst in progress
done  output  1  one-cycle pulse at burst completion

Behaviour:
- Reset (rst=0, asynchronous, dominates all inputs): Q=0, busy=0, done=0, state=IDLE, internal count=0, latched mode=000. Reset mid-burst aborts the burst; no done pulse.
- Mode encoding:
  - 000: hold
  - 001: SR, Q <= {din_r, Q[W-1:1]}
  - 010: SL, Q <= {Q[W-2:0], din_l}
  - 011: ROR, Q <= {Q[0], Q[W-1:1]}
  - 100: ROL, Q <= {Q[W-2:0], Q[W-1]}
  - 101: load, Q <= pdata
  - 110: ASR, Q <= {Q[W-1], Q[W-1:1]}
  - 111: clear, Q <= 0
- Shift-type modes are 001, 010, 011, 100 and 110.
- FSM states are IDLE and BUSY.
- IDLE:
  - If start=1 and mode is shift-type and count!=0: latch mode and count, go to BUSY, busy=1 from next cycle. Q is unchanged on the accepting edge.
  - If start=1 and mode is shift-type and count==0: stay IDLE, Q unchanged, done=1 for one cycle.
  - If start=1 and mode is not shift-type: start is ignored, and the manual rule below applies.
  - Otherwise, if en=1, apply mode for one cycle (latency 1: result visible after the edge). If en=0, hold.
- BUSY:
  - Each edge applies the latched mode once and decrements the remaining count.
  - din_l/din_r are sampled live every cycle.
  - en, mode, start, count and pdata are ignored.
  - On the edge performing the final shift: state goes to IDLE, busy=0, and done=1 for exactly one cycle, coincident with the final Q.
  - busy is high for exactly count cycles.
- done is registered and is 0 in every cycle other than the completion pulse.
- A start held high after completion is re-evaluated in IDLE; a new burst is accepted on the cycle after done.
- Back-to-back: start=1 on the same cycle done=1 is accepted, because the FSM is already IDLE.
- No arithmetic overflow is possible: Q width is fixed, and shifted-out bits are discarded.

Test Plan:
- Reset: run a burst, drive rst=0 asynchronously between edges -> Q=0x00, busy=0, done=0 immediately; no done pulse after rst is released.
- Load/shift, WIDTH=8:
  - mode=101, pdata=0xA5, en=1 -> Q=0xA5.
  - Then mode=001, din_r=1 -> Q=0xD2, sout_r=0.
  - Then mode=010, din_l=0 -> Q=0xA4.
  - en=0 holds the value.
- Rotate/ASR:
  - Load 0x81, mode=100 -> Q=0x03.
  - Load 0x81, mode=011 -> Q=0xC0.
  - Load 0x80, mode=110 -> Q=0xC0, then 0xE0.
- Burst:
  - Load 0x01; start=1, mode=010, count=3, din_l=0 for one cycle -> busy=1 for 3 cycles, Q=0x02, 0x04, 0x08, done=1 with Q=0x08.
  - Mode/en changes during busy have no effect.
- Edge cases:
  - start with count=0 -> single done pulse, Q unchanged, busy stays 0.
  - start with mode=101 -> behaves as a manual load, no busy.
  - start held high -> a second burst begins on the cycle after done.
